// File: rtl/pulse_window_counter_if.sv
// Control/status bundle between the pulse-rate FSM (master) and the
// window counting datapath (slave).
interface pulse_window_counter_if #(
    parameter int unsigned CNT_W = 8
);
    logic             pulse_in;
    logic             en_count;
    logic             clear;
    logic             en_cap;
    logic             end_count;
    logic             overflow;
    logic [CNT_W-1:0] bpm;
    logic             bpm_valid;

    // en_cap is a one-cycle command with no back-pressure: bpm/bpm_valid
    // update on the edge that samples en_cap=1 and hold until the next capture.
    modport master (
        output pulse_in, en_count, clear, en_cap,
        input  end_count, overflow, bpm, bpm_valid
    );

    modport slave (
        input  pulse_in, en_count, clear, en_cap,
        output end_count, overflow, bpm, bpm_valid
    );
endinterface

// File: rtl/pulse_window_counter.sv
// Pulse window counter: synchronizes a sensor pulse, counts rising edges over a
// WINDOW_S-second window and captures the result. Optional lockout: PWC_DEBOUNCE_EN.
module pulse_window_counter #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned WINDOW_S      = 60,
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned THRESH        = 120,
    parameter int unsigned DEBOUNCE_CYC  = 1_000_000
) (
    input logic                  clk,
    input logic                  rst_n,
    pulse_window_counter_if.slave bus
);
    localparam int unsigned PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned SEC_W = (WINDOW_S > 1) ? $clog2(WINDOW_S) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);
    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(WINDOW_S - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    if (TICKS_PER_SEC == 0 || WINDOW_S == 0 || DEBOUNCE_CYC == 0) begin : g_bad_param
        $error("pulse_window_counter: TICKS_PER_SEC, WINDOW_S and DEBOUNCE_CYC must be nonzero");
    end

    logic             sync1_q;
    logic             sync2_q;
    logic             prev_q;
    logic             rise;
    logic             active;
    logic             take;
    logic             sec_tick;
    logic [PRE_W-1:0] pre_q;
    logic [SEC_W-1:0] sec_q;
    logic             end_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_q;
    logic [CNT_W-1:0] bpm_q;
    logic             bpm_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= bus.pulse_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise     = sync2_q & ~prev_q;
    assign active   = bus.en_count & ~bus.clear & ~end_q;
    assign sec_tick = active && (pre_q == PRE_LAST);

`ifdef PWC_DEBOUNCE_EN
    localparam int unsigned LOCK_W = $clog2(DEBOUNCE_CYC + 1);
    logic [LOCK_W-1:0] lock_q;

    assign take = active & rise & (lock_q == '0);

    // Lockout only runs down while counting is enabled, so a pause holds it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= '0;
        end else if (bus.clear) begin
            lock_q <= '0;
        end else if (take) begin
            lock_q <= LOCK_W'(DEBOUNCE_CYC);
        end else if (bus.en_count && lock_q != '0) begin
            lock_q <= lock_q - LOCK_W'(1);
        end
    end
`else
    assign take = active & rise;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            sec_q <= '0;
            end_q <= 1'b0;
        end else if (bus.clear) begin
            pre_q <= '0;
            sec_q <= '0;
            end_q <= 1'b0;
        end else if (active) begin
            pre_q <= sec_tick ? '0 : pre_q + PRE_W'(1);
            if (sec_tick) begin
                if (sec_q == SEC_LAST) begin
                    end_q <= 1'b1;
                end else begin
                    sec_q <= sec_q + SEC_W'(1);
                end
            end
        end
    end

    always_comb begin
        cnt_next = cnt_q;
        if (bus.clear) begin
            cnt_next = '0;
        end else if (take && cnt_q != CNT_MAX) begin
            cnt_next = cnt_q + CNT_W'(1);
        end
    end

    // Overflow looks at the next count so it rises with the count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_next;
            ovf_q <= bus.clear ? 1'b0 : (ovf_q | (32'(cnt_next) > THRESH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bpm_q       <= '0;
            bpm_valid_q <= 1'b0;
        end else if (bus.en_cap) begin
            bpm_q       <= cnt_q;
            bpm_valid_q <= 1'b1;
        end
    end

    assign bus.end_count = end_q;
    assign bus.overflow  = ovf_q;
    assign bus.bpm       = bpm_q;
    assign bus.bpm_valid = bpm_valid_q;
endmodule

// File: tb/tb_pulse_window_counter.sv
// Bench for pulse_window_counter: two instances (short window / wide window with
// narrow count) driven by shared stimulus and checked against a cycle model.
module tb_pulse_window_counter;
    localparam int A_TPS = 4;
    localparam int A_WIN = 3;
    localparam int A_CW  = 8;
    localparam int B_TPS = 8;
    localparam int B_WIN = 5;
    localparam int B_CW  = 3;
    localparam int THR   = 5;
    localparam int DB    = 10;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic pulse_in = 1'b0;
    logic en_count = 1'b0;
    logic clear    = 1'b0;
    logic en_cap   = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pulse_window_counter_if #(.CNT_W(A_CW)) bus_a ();
    pulse_window_counter_if #(.CNT_W(B_CW)) bus_b ();

    assign bus_a.pulse_in = pulse_in;
    assign bus_a.en_count = en_count;
    assign bus_a.clear    = clear;
    assign bus_a.en_cap   = en_cap;
    assign bus_b.pulse_in = pulse_in;
    assign bus_b.en_count = en_count;
    assign bus_b.clear    = clear;
    assign bus_b.en_cap   = en_cap;

    pulse_window_counter #(
        .TICKS_PER_SEC(A_TPS), .WINDOW_S(A_WIN), .CNT_W(A_CW),
        .THRESH(THR), .DEBOUNCE_CYC(DB)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );

    pulse_window_counter #(
        .TICKS_PER_SEC(B_TPS), .WINDOW_S(B_WIN), .CNT_W(B_CW),
        .THRESH(THR), .DEBOUNCE_CYC(DB)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    // Behavioural model: elapsed counts enabled cycles; hist[0] is the pulse
    // level sampled one edge ago, hist[2] three edges ago.
    typedef struct packed {
        int       elapsed;
        int       count;
        int       lock;
        int       bpm;
        bit       ovf;
        bit       endc;
        bit       bpmv;
        bit [2:0] hist;
    } model_t;

    model_t ma;
    model_t mb;

    function automatic model_t step(input model_t m, input bit p, input bit en,
                                    input bit clr, input bit cap,
                                    input int tps, input int win, input int cw);
        model_t n;
        bit     ok;
        n  = m;
        ok = m.hist[1] && !m.hist[2];
`ifdef PWC_DEBOUNCE_EN
        ok = ok && (m.lock == 0);
`endif
        if (cap) begin
            n.bpm  = m.count;
            n.bpmv = 1'b1;
        end
        if (clr) begin
            n.elapsed = 0;
            n.count   = 0;
            n.lock    = 0;
            n.ovf     = 1'b0;
            n.endc    = 1'b0;
        end else begin
            if (en && !m.endc) begin
                if (ok && m.count < (1 << cw) - 1) n.count = m.count + 1;
                n.elapsed = m.elapsed + 1;
                if (n.elapsed == tps * win) n.endc = 1'b1;
            end
            if (n.count > THR) n.ovf = 1'b1;
`ifdef PWC_DEBOUNCE_EN
            if (en) begin
                if (ok && !m.endc) n.lock = DB;
                else if (m.lock > 0) n.lock = m.lock - 1;
            end
`endif
        end
        n.hist = {m.hist[1:0], p};
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= '0;
            mb <= '0;
        end else begin
            ma <= step(ma, pulse_in, en_count, clear, en_cap, A_TPS, A_WIN, A_CW);
            mb <= step(mb, pulse_in, en_count, clear, en_cap, B_TPS, B_WIN, B_CW);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of both instances against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("a_end_count", int'(bus_a.end_count), int'(ma.endc));
            check("a_overflow",  int'(bus_a.overflow),  int'(ma.ovf));
            check("a_bpm",       int'(bus_a.bpm),       ma.bpm);
            check("a_bpm_valid", int'(bus_a.bpm_valid), int'(ma.bpmv));
            check("b_end_count", int'(bus_b.end_count), int'(mb.endc));
            check("b_overflow",  int'(bus_b.overflow),  int'(mb.ovf));
            check("b_bpm",       int'(bus_b.bpm),       mb.bpm);
            check("b_bpm_valid", int'(bus_b.bpm_valid), int'(mb.bpmv));
        end
    end

    task automatic cyc(input bit en, input bit p, input bit clr = 1'b0, input bit cap = 1'b0);
        en_count = en;
        pulse_in = p;
        clear    = clr;
        en_cap   = cap;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a_end"}, int'(bus_a.end_count), 0);
        check({tag, "_a_ovf"}, int'(bus_a.overflow), 0);
        check({tag, "_a_bpm"}, int'(bus_a.bpm), 0);
        check({tag, "_a_vld"}, int'(bus_a.bpm_valid), 0);
        check({tag, "_b_bpm"}, int'(bus_b.bpm), 0);
        check({tag, "_b_vld"}, int'(bus_b.bpm_valid), 0);
    endtask

    initial begin
        logic [11:0] win_pat;
        bit          p;
        win_pat = 12'b0000_1101_1011;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Window: three pulses, end_count after exactly 12 enabled cycles
        cyc(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++) cyc(1'b1, win_pat[i]);
        check("win_end_before", int'(bus_a.end_count), 0);
        cyc(1'b1, win_pat[11]);
        check("win_end_at_12", int'(bus_a.end_count), 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("win_bpm", int'(bus_a.bpm), 3);
        check("win_bpm_valid", int'(bus_a.bpm_valid), 1);
        check("win_ovf", int'(bus_a.overflow), 0);
        check("win_end_held", int'(bus_a.end_count), 1);

        // Asynchronous reset mid-window with count 4 and bpm 2
        cyc(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b1, (i % 2) == 0, 1'b0, i == 5);
        check("pre_rst_bpm", int'(bus_a.bpm), 2);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 11; i++) cyc(1'b1, 1'b0);
        check("rst_end_before", int'(bus_a.end_count), 0);
        cyc(1'b1, 1'b0);
        check("rst_end_at_12", int'(bus_a.end_count), 1);

        // Overflow on B: six pulses spaced 4 cycles, sixth edge at cycle 23
        cyc(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, (i % 4) < 2 && i < 24);
            if (i == 21) check("ovf_before", int'(bus_b.overflow), 0);
            if (i == 22) check("ovf_at_6", int'(bus_b.overflow), 1);
            if (i == 38) check("ovf_end_before", int'(bus_b.end_count), 0);
        end
        check("ovf_end_at_40", int'(bus_b.end_count), 1);
        check("ovf_held", int'(bus_b.overflow), 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("ovf_bpm", int'(bus_b.bpm), 6);
        cyc(1'b1, 1'b0, 1'b1);
        check("clr_ovf", int'(bus_b.overflow), 0);
        check("clr_end", int'(bus_b.end_count), 0);
        check("clr_bpm_kept", int'(bus_b.bpm), 6);

        // Pause for 5 cycles with dropped pulses; pulse edge on the final tick
        cyc(1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 22; i++) begin
            cyc(!(i >= 4 && i <= 8), (i == 4) || (i == 6) || (i == 15) || (i == 16) ||
                                     (i == 18) || (i == 19));
            if (i == 16) check("pause_end_before", int'(bus_a.end_count), 0);
            if (i == 17) check("pause_end_at_17", int'(bus_a.end_count), 1);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("pause_bpm", int'(bus_a.bpm), 1);

        // Saturation on B (3-bit count)
        cyc(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 24; i++) cyc(1'b1, (i % 2) == 0 && i < 20);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("sat_bpm", int'(bus_b.bpm), 7);
        check("sat_ovf", int'(bus_b.overflow), 1);

        // Debounce pattern on B: rises at cycles 1, 5, 17
        cyc(1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 22; i++)
            cyc(1'b1, (i == 1) || (i == 2) || (i == 5) || (i == 6) || (i == 17) || (i == 18));
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
`ifdef PWC_DEBOUNCE_EN
        check("debounce_bpm", int'(bus_b.bpm), 2);
`else
        check("debounce_bpm", int'(bus_b.bpm), 3);
`endif

        // Randomized traffic, including occasional asynchronous resets
        p = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) p = ~p;
            cyc($urandom_range(0, 9) != 0, p, $urandom_range(0, 59) == 0,
                $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 999) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
